// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drains the pipe, writes mepc/mcause/mstatus in order, then redirects.
// Optional TRAP_VECTORED_EN: vectored interrupt targets when mtvec_i[1:0] == 2'b01.
module trap_ctrl #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_req,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_req,
  input  logic            irq_timer,
  input  logic            mie_mtie,
  input  logic [XLEN-1:0] irq_pc,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            drained,
  output logic            flush,
  output logic            mepc_w_e,
  output logic            mcause_w_e,
  output logic            mstatus_w_e,
  output logic [XLEN-1:0] mepc_wdata,
  output logic [XLEN-1:0] mcause_wdata,
  output logic [XLEN-1:0] mstatus_wdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            exc_ack,
  output logic            busy
);

  // state | meaning
  // IDLE  | waiting for exception / interrupt / mret
  // DRAIN | front end killed, waiting for drained or drain timeout
  // SAVE  | mepc + mcause written (traps only)
  // STAT  | mstatus written
  // JUMP  | redirect + exc_ack pulse
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_SAVE, S_STAT, S_JUMP} state_t;

  localparam int CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (DRAIN_MAX > 0) ? CW'(DRAIN_MAX - 1) : '0;
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          r_state;
  logic            r_is_mret;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_cnt;

  logic            w_irq_take;
  logic            w_cnt_tc;
  logic            w_drain_done;
  logic [XLEN-1:0] w_trap_mstatus;
  logic [XLEN-1:0] w_mret_mstatus;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;
  logic [XLEN-1:0] w_target;

  assign w_irq_take   = irq_timer & mie_mtie & mstatus_i[3];
  assign w_cnt_tc     = (DRAIN_MAX != 0) && (r_cnt == '0);
  assign w_drain_done = drained | w_cnt_tc;
  assign w_base       = mtvec_i & ALIGN_MASK;

`ifdef TRAP_VECTORED_EN
  // the interrupt bit of the latched cause identifies an interrupt trap
  assign w_trap_target = (r_cause[XLEN-1] && (mtvec_i[1:0] == 2'b01))
                         ? w_base + {{(XLEN-8){1'b0}}, r_cause[5:0], 2'b00}
                         : w_base;
`else
  assign w_trap_target = w_base;
`endif

  assign w_target = r_is_mret ? (mepc_i & ALIGN_MASK) : w_trap_target;

  always_comb begin
    w_trap_mstatus        = mstatus_i;
    w_trap_mstatus[7]     = mstatus_i[3];
    w_trap_mstatus[3]     = 1'b0;
    w_trap_mstatus[12:11] = 2'b11;
    w_mret_mstatus        = mstatus_i;
    w_mret_mstatus[3]     = mstatus_i[7];
    w_mret_mstatus[7]     = 1'b1;
    w_mret_mstatus[12:11] = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_is_mret     <= 1'b0;
      r_cause       <= '0;
      r_pc          <= '0;
      r_cnt         <= '0;
      flush         <= 1'b0;
      busy          <= 1'b0;
      mepc_w_e      <= 1'b0;
      mcause_w_e    <= 1'b0;
      mstatus_w_e   <= 1'b0;
      mepc_wdata    <= '0;
      mcause_wdata  <= '0;
      mstatus_wdata <= '0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      exc_ack       <= 1'b0;
    end else begin
      mepc_w_e      <= 1'b0;
      mcause_w_e    <= 1'b0;
      mstatus_w_e   <= 1'b0;
      mepc_wdata    <= '0;
      mcause_wdata  <= '0;
      mstatus_wdata <= '0;
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      exc_ack       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exc_req || w_irq_take || mret_req) begin
            r_state <= S_DRAIN;
            r_cnt   <= CNT_LOAD;
            flush   <= 1'b1;
            busy    <= 1'b1;
          end
          if (exc_req) begin
            r_is_mret <= 1'b0;
            r_cause   <= XLEN'(exc_cause);
            r_pc      <= exc_pc;
          end else if (w_irq_take) begin
            r_is_mret <= 1'b0;
            r_cause   <= IRQ_CAUSE;
            r_pc      <= irq_pc;
          end else if (mret_req) begin
            r_is_mret <= 1'b1;
            r_cause   <= '0;
            r_pc      <= '0;
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            if (r_is_mret) begin
              r_state       <= S_STAT;
              mstatus_w_e   <= 1'b1;
              mstatus_wdata <= w_mret_mstatus;
            end else begin
              r_state      <= S_SAVE;
              mepc_w_e     <= 1'b1;
              mcause_w_e   <= 1'b1;
              mepc_wdata   <= r_pc;
              mcause_wdata <= r_cause;
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SAVE: begin
          r_state       <= S_STAT;
          mstatus_w_e   <= 1'b1;
          mstatus_wdata <= w_trap_mstatus;
        end
        S_STAT: begin
          r_state     <= S_JUMP;
          redirect    <= 1'b1;
          exc_ack     <= 1'b1;
          redirect_pc <= w_target;
        end
        S_JUMP: begin
          r_state <= S_IDLE;
          flush   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          flush   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected CSR-write/redirect events, a monitor checks them.
module tb_trap_ctrl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            exc_req, mret_req, irq_timer, mie_mtie, drained;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc, irq_pc, mstatus_i, mepc_i, mtvec_i;
  logic            flush, mepc_w_e, mcause_w_e, mstatus_w_e, redirect, exc_ack, busy;
  logic [XLEN-1:0] mepc_wdata, mcause_wdata, mstatus_wdata, redirect_pc;

  trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_req(mret_req), .irq_timer(irq_timer), .mie_mtie(mie_mtie), .irq_pc(irq_pc),
    .mstatus_i(mstatus_i), .mepc_i(mepc_i), .mtvec_i(mtvec_i), .drained(drained),
    .flush(flush), .mepc_w_e(mepc_w_e), .mcause_w_e(mcause_w_e), .mstatus_w_e(mstatus_w_e),
    .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata), .mstatus_wdata(mstatus_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .exc_ack(exc_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [4:0]  fl;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mstat;
    logic [63:0] rpc;
  } ev_t;

  localparam logic [4:0] F_SAVE = 5'b11000;
  localparam logic [4:0] F_STAT = 5'b00100;
  localparam logic [4:0] F_JUMP = 5'b00011;
  localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

  ev_t exp_q[$];
  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [4:0] f, input logic [63:0] m_pc,
                         input logic [63:0] m_cause, input logic [63:0] m_stat, input logic [63:0] rpc);
    ev_t e;
    e.cyc = c; e.fl = f; e.mepc = m_pc; e.mcause = m_cause; e.mstat = m_stat; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    logic [4:0] fl;
    fl = {mepc_w_e, mcause_w_e, mstatus_w_e, redirect, exc_ack};
    if (rst_n && (fl != 5'b0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {59'd0, fl}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_cycle", 64'(cyc), 64'(e.cyc));
        chk("ev_flags", {59'd0, fl}, {59'd0, e.fl});
        chk("ev_mepc_wdata", mepc_wdata, e.mepc);
        chk("ev_mcause_wdata", mcause_wdata, e.mcause);
        chk("ev_mstatus_wdata", mstatus_wdata, e.mstat);
        chk("ev_redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  task automatic wait_ack(output int j);
    j = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exc_ack) begin
        j = cyc;
        break;
      end
    end
    if (j < 0) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, {57'd0, flush, mepc_w_e, mcause_w_e, mstatus_w_e, redirect, exc_ack, busy}, 64'd0);
    chk({name, "_data"}, mepc_wdata | mcause_wdata | mstatus_wdata | redirect_pc, 64'd0);
  endtask

  logic [63:0] irq_tgt;
  int n, j;

  initial begin
`ifdef TRAP_VECTORED_EN
    irq_tgt = 64'h8000_011C;
`else
    irq_tgt = 64'h8000_0100;
`endif
    exc_req = 0; mret_req = 0; irq_timer = 0; mie_mtie = 0; drained = 1;
    exc_cause = 0; exc_pc = 0; irq_pc = 0; mstatus_i = 0; mepc_i = 0; mtvec_i = 0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // ecall
    n = cyc;
    exc_req = 1; exc_cause = 4'd11; exc_pc = 64'h8000_0010;
    mtvec_i = 64'h8000_0100; mstatus_i = 64'hA_0000_1808; drained = 1;
    push_ev(n + 2, F_SAVE, 64'h8000_0010, 64'd11, 64'd0, 64'd0);
    push_ev(n + 3, F_STAT, 64'd0, 64'd0, 64'hA_0000_1880, 64'd0);
    push_ev(n + 4, F_JUMP, 64'd0, 64'd0, 64'd0, 64'h8000_0100);
    @(negedge clk);
    chk("drain_flush_busy", {62'd0, flush, busy}, 64'd3);
    wait_ack(j);
    exc_req = 0;
    @(negedge clk);
    chk("idle_after_ecall", {63'd0, busy}, 64'd0);

    // timer interrupt, vectored mtvec mode
    n = cyc;
    mie_mtie = 1; irq_timer = 1; irq_pc = 64'h8000_0020; mtvec_i = 64'h8000_0101;
    push_ev(n + 2, F_SAVE, 64'h8000_0020, IRQ_CAUSE, 64'd0, 64'd0);
    push_ev(n + 3, F_STAT, 64'd0, 64'd0, 64'hA_0000_1880, 64'd0);
    push_ev(n + 4, F_JUMP, 64'd0, 64'd0, 64'd0, irq_tgt);
    wait_ack(j);
    irq_timer = 0;
    @(negedge clk);

    // masked interrupt: MIE clear
    mstatus_i = 64'hA_0000_1800; irq_timer = 1; mtvec_i = 64'h8000_0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("masked_irq_idle", {62'd0, busy, flush}, 64'd0);
    end
    irq_timer = 0;

    // mret
    @(negedge clk);
    n = cyc;
    mret_req = 1; mepc_i = 64'h8000_0014; mstatus_i = 64'hA_0000_1880;
    push_ev(n + 2, F_STAT, 64'd0, 64'd0, 64'hA_0000_1888, 64'd0);
    push_ev(n + 3, F_JUMP, 64'd0, 64'd0, 64'd0, 64'h8000_0014);
    wait_ack(j);
    mret_req = 0;
    @(negedge clk);

    // exception + interrupt together with a 5-cycle drain stall
    n = cyc;
    mstatus_i = 64'hA_0000_1808; mie_mtie = 1; irq_timer = 1; irq_pc = 64'h8000_0040;
    exc_req = 1; exc_cause = 4'd2; exc_pc = 64'h8000_0030; mtvec_i = 64'h8000_0200; drained = 0;
    push_ev(n + 6, F_SAVE, 64'h8000_0030, 64'd2, 64'd0, 64'd0);
    push_ev(n + 7, F_STAT, 64'd0, 64'd0, 64'hA_0000_1880, 64'd0);
    push_ev(n + 8, F_JUMP, 64'd0, 64'd0, 64'd0, 64'h8000_0200);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_flush", {63'd0, flush}, 64'd1);
    end
    drained = 1;
    wait_ack(j);
    exc_req = 0;
    push_ev(j + 3, F_SAVE, 64'h8000_0040, IRQ_CAUSE, 64'd0, 64'd0);
    push_ev(j + 4, F_STAT, 64'd0, 64'd0, 64'hA_0000_1880, 64'd0);
    push_ev(j + 5, F_JUMP, 64'd0, 64'd0, 64'd0, 64'h8000_0200);
    @(negedge clk);
    chk("idle_between_traps", {63'd0, busy}, 64'd0);
    wait_ack(j);
    irq_timer = 0;
    @(negedge clk);

    // drain timeout at DRAIN_MAX=15, late mret ignored while busy
    n = cyc;
    exc_req = 1; exc_cause = 4'd3; exc_pc = 64'h8000_0050; mtvec_i = 64'h8000_0300; drained = 0;
    push_ev(n + 16, F_SAVE, 64'h8000_0050, 64'd3, 64'd0, 64'd0);
    push_ev(n + 17, F_STAT, 64'd0, 64'd0, 64'hA_0000_1880, 64'd0);
    push_ev(n + 18, F_JUMP, 64'd0, 64'd0, 64'd0, 64'h8000_0300);
    repeat (4) @(negedge clk);
    mret_req = 1;
    wait_ack(j);
    exc_req = 0; mret_req = 0; drained = 1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_timeout", {63'd0, busy}, 64'd0);
    end

    // reset during STAT
    n = cyc;
    exc_req = 1; exc_cause = 4'd11; exc_pc = 64'h8000_0060; mtvec_i = 64'h8000_0100;
    push_ev(n + 2, F_SAVE, 64'h8000_0060, 64'd11, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    exc_req = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1 chk_all_zero("reset_mid_op");
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_reset", {62'd0, busy, flush}, 64'd0);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Multi-cycle trap sequencer in front of the machine-mode CSR register file (mepc/mcause/mstatus/mtvec).
- Arbitrates synchronous exceptions, machine timer interrupt and mret from the commit stage.
- Drains the pipeline, writes the CSRs in a fixed order through the CSR write-enable ports, then issues one PC redirect.
- Replaces the single-cycle ecall/mret shortcut in the CSR datapath.

Parameters:
XLEN, 64, datapath/CSR width
DRAIN_MAX, 15, max cycles waiting for drained before forcing progress; 0 = wait forever

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exc_req  in  1  synchronous exception pending at commit; held until exc_ack
exc_cause  in  4  exception code (11 = ecall-M, 3 = ebreak, 2 = illegal)
exc_pc  in  XLEN  pc of faulting instruction
mret_req  in  1  mret at commit; held until exc_ack
irq_timer  in  1  MTIP level
mie_mtie  in  1  MIE.MTIE
irq_pc  in  XLEN  pc of next instruction to commit (interrupt mepc)
mstatus_i, mepc_i, mtvec_i  in  XLEN  current CSR values
drained  in  1  pipeline empty, no outstanding memory op
flush  out  1  kill/stall pipeline front end
mepc_w_e, mcause_w_e, mstatus_w_e  out  1  CSR write enables
mepc_wdata, mcause_wdata, mstatus_wdata  out  XLEN  CSR write data
redirect  out  1  one-cycle PC redirect pulse
redirect_pc  out  XLEN  redirect target
exc_ack  out  1  one-cycle; pulses with redirect
busy  out  1  FSM not IDLE

Behaviour:
- Async reset: FSM=IDLE; all outputs 0; latched kind/cause/pc cleared. Reset mid-sequence aborts with no further CSR writes.
- States: IDLE, DRAIN, SAVE, STAT, JUMP.
- IDLE:
  - Evaluate in priority order: exc_req > interrupt > mret_req.
  - Interrupt taken iff irq_timer & mie_mtie & mstatus_i[3].
  - Latch kind, cause and pc, then go to DRAIN.
  - Exception cause = {60'b0, exc_cause}. Interrupt cause = 64'h8000_0000_0000_0007.
  - Latched pc: exc_pc for exceptions, irq_pc for interrupts.
- DRAIN:
  - flush=1 in this state and in every state until JUMP inclusive.
  - Leave when drained=1 or when the counter reaches DRAIN_MAX (DRAIN_MAX≠0).
  - Trap goes to SAVE; mret goes to STAT.
- SAVE: mepc_w_e=mcause_w_e=1 for exactly one cycle, with latched pc and cause.
- STAT: mstatus_w_e=1 for one cycle. wdata is derived from mstatus_i, all other bits unchanged:
  - Trap: bit7 (MPIE) ← bit3 (MIE); bit3 ← 0; bits[12:11] (MPP) ← 2'b11.
  - mret: bit3 ← bit7; bit7 ← 1; bits[12:11] ← 2'b11.
- JUMP: redirect=exc_ack=1 for one cycle, then IDLE.
  - Trap target = {mtvec_i[XLEN-1:2], 2'b00}.
  - mret target = {mepc_i[XLEN-1:2], 2'b00}.
- Latency from acceptance, drained already 1: trap = 4 cycles to redirect (DRAIN, SAVE, STAT, JUMP); mret = 3 cycles.
- Latched state is frozen after acceptance:
  - irq_timer dropping, or a new request arriving, mid-sequence has no effect.
  - New requests are ignored while busy=1 and re-evaluated in the first IDLE cycle after JUMP.
- Write enables are mutually exclusive by state; wdata is 0 whenever the matching w_e is 0.
- exc_req and mret_req both high: exception wins. mret is not acked and must be dropped by the pipeline flush.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: for interrupts with mtvec_i[1:0]==2'b01, target = {mtvec_i[XLEN-1:2],2'b00} + 4*cause[5:0] (timer: base+0x1C). Exceptions always use base.
- Undefined: mtvec_i[1:0] is ignored; every trap targets base.

Test Plan:
- ecall: exc_req=1, exc_cause=11, exc_pc=0x8000_0010, mtvec_i=0x8000_0100, mstatus_i=0xA_0000_1808, drained=1 -> cycle+2: mepc=0x8000_0010, mcause=11; cycle+3: mstatus_wdata=0xA_0000_1880; cycle+4: redirect to 0x8000_0100 with exc_ack.
- Timer irq enabled (MIE=1, MTIE=1), irq_pc=0x8000_0020 -> mcause_wdata=0x8000_0000_0000_0007, mepc_wdata=0x8000_0020. With TRAP_VECTORED_EN and mtvec_i=0x8000_0101 -> redirect_pc=0x8000_011C.
- Masked irq: mstatus_i[3]=0, irq_timer=1 -> stays IDLE, no w_e, busy=0.
- mret: mepc_i=0x8000_0014, mstatus_i=0xA_0000_1880 -> mstatus_wdata=0xA_0000_1888, redirect_pc=0x8000_0014, 3 cycles after acceptance, no mepc/mcause write.
- exc_req, irq and drain-stall together: exc_req+irq_timer with drained=0 for 5 cycles -> exception serviced first, flush held through DRAIN; irq taken after return to IDLE. With DRAIN_MAX=3 -> SAVE entered after 3 DRAIN cycles.
- Reset mid-op: rst_n low during STAT -> all outputs 0 immediately, no mstatus write, IDLE after release.
